// File: rtl/ins_mem_arbiter_if.sv
// Bus between the four cores, the instruction-memory arbiter and ram_instruction.
// The arbiter connects through the slave modport; the cores plus memory sit on master.
interface ins_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int INS_W  = 16
);
   logic [3:0]        req;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] addr2;
   logic [ADDR_W-1:0] addr3;
   logic [ADDR_W-1:0] addr4;
   logic [3:0]        ack;
   logic [INS_W-1:0]  ins_out;
   logic [3:0]        grant;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic [INS_W-1:0]  mem_data;

   modport slave (
      input  req, addr1, addr2, addr3, addr4, mem_data,
      output ack, ins_out, grant, busy, mem_addr, mem_read
   );

   modport master (
      output req, addr1, addr2, addr3, addr4, mem_data,
      input  ack, ins_out, grant, busy, mem_addr, mem_read
   );
endinterface

// File: rtl/ins_mem_arbiter.sv
// Registered request/ack arbiter sharing the single-ported instruction memory
// between four cores. Default build is round-robin; defining
// INSARB_FIXED_PRIO_EN selects fixed priority core1 > core2 > core3 > core4.
// Transaction: IDLE (arbitrate) -> ISSUE (1-cycle read strobe) ->
// WAIT (RD_LAT cycles) -> RESP (1-cycle ack pulse).
module ins_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int INS_W  = 16,
   parameter int RD_LAT = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   ins_mem_arbiter_if.slave bus
);

   if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
      $error("ins_mem_arbiter: RD_LAT=%0d outside legal range 1..3", RD_LAT);
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state, state_nx;
   logic [1:0]        win;       // arbitration winner this cycle
   logic [1:0]        win_q;     // owner of the transaction in flight
   logic [ADDR_W-1:0] addr_sel;
   logic [ADDR_W-1:0] addr_q;    // address frozen at grant
   logic [INS_W-1:0]  ins_q;
   logic [1:0]        cnt;
   logic              any_req;
   logic [3:0]        owner_oh;

   assign any_req  = |bus.req;
   assign owner_oh = 4'b0001 << win_q;

`ifdef INSARB_FIXED_PRIO_EN
   // Fixed priority: lowest-numbered requesting core wins
   always_comb begin
      win = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (bus.req[i]) win = 2'(i);
   end
`else
   logic [1:0] last;
   logic [1:0] rr_idx;
   logic       rr_found;

   // Round-robin: first requester found scanning upward from last+1
   always_comb begin
      win      = last;
      rr_idx   = last;
      rr_found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         rr_idx = last + 2'(i);
         if (!rr_found && bus.req[rr_idx]) begin
            win      = rr_idx;
            rr_found = 1'b1;
         end
      end
   end

   // Pointer advances only when a grant is actually taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       last <= 2'd3;
      else if (state == IDLE && any_req) last <= win;
   end
`endif

   // Select the winner's address for latching at grant
   always_comb begin
      case (win)
         2'd0:    addr_sel = bus.addr1;
         2'd1:    addr_sel = bus.addr2;
         2'd2:    addr_sel = bus.addr3;
         default: addr_sel = bus.addr4;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (cnt == 2'd0) state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end

   // Transaction datapath: latch owner/address at grant, count latency, capture data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q  <= 2'd0;
         addr_q <= '0;
         ins_q  <= '0;
         cnt    <= 2'd0;
      end else begin
         if (state == IDLE && any_req) begin
            win_q  <= win;
            addr_q <= addr_sel;
         end
         if (state == ISSUE) cnt <= 2'(RD_LAT - 1);
         if (state == WAIT) begin
            if (cnt == 2'd0) ins_q <= bus.mem_data;
            else             cnt   <= cnt - 2'd1;
         end
      end
   end

   // mem_addr simply holds the latched address, so it keeps its value after ISSUE
   assign bus.mem_addr = addr_q;
   assign bus.ins_out  = ins_q;

   // Output decode from state
   always_comb begin
      bus.busy     = (state != IDLE);
      bus.mem_read = (state == ISSUE);
      bus.grant    = (state != IDLE) ? owner_oh : 4'b0000;
      bus.ack      = (state == RESP) ? owner_oh : 4'b0000;
   end

endmodule
